// File: rtl/soc_rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// soc_rst_seq_pkg
// Shared definitions for the SoC reset sequencer:
//   - 3-bit state encodings exported on o_state
//   - state_e enum built from those encodings
//   - cnt_width(): counter width able to hold 0..max without wrapping
// -----------------------------------------------------------------------------
package soc_rst_seq_pkg;

  localparam logic [2:0] ST_ENC_PLL_RST   = 3'd0;
  localparam logic [2:0] ST_ENC_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_ENC_HOLD      = 3'd2;
  localparam logic [2:0] ST_ENC_RUN       = 3'd3;
  localparam logic [2:0] ST_ENC_FAULT     = 3'd4;

  typedef enum logic [2:0] {
    ST_PLL_RST   = ST_ENC_PLL_RST,
    ST_WAIT_LOCK = ST_ENC_WAIT_LOCK,
    ST_HOLD      = ST_ENC_HOLD,
    ST_RUN       = ST_ENC_RUN,
    ST_FAULT     = ST_ENC_FAULT
  } state_e;

  // Width of a counter spanning 0..max_val; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    if (max_val == 32'd0) begin
      w = 32'd1;
    end else begin
      w = $clog2(max_val + 32'd1);
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous level.
// Ports:
//   i_clk   - destination clock
//   i_rst_n - asynchronous active-low reset, both flops clear to 0
//   i_d     - asynchronous input level
//   o_q     - synchronised level, two i_clk edges of latency
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/soc_rst_seq.sv
// -----------------------------------------------------------------------------
// soc_rst_seq
// Power-on reset sequencer between the board button debouncer and the
// PLL / SoC core. Pulses the PLL reset, waits for lock, requires a stable
// lock for HOLD_CYCLES before releasing the SoC reset, and drops back into
// the PLL reset phase whenever lock is lost.
//
// Parameters:
//   PLL_RST_CYCLES - cycles o_pll_rst is held per attempt (1..65535)
//   LOCK_TIMEOUT   - cycles allowed in WAIT_LOCK per attempt (1..2^20-1)
//   HOLD_CYCLES    - consecutive synchronised-lock cycles before release,
//                    counted from the WAIT_LOCK cycle that first sees lock
//                    (1..65535)
//   RETRY_MAX      - failed attempts tolerated before FAULT (0..15)
// Ports:
//   i_clk       - 50 MHz reference clock
//   i_rst_n     - asynchronous active-low reset (debounced button)
//   i_pll_lock  - PLL lock, asynchronous to i_clk
//   o_pll_rst   - active-high PLL reset (registered)
//   o_soc_rst_n - active-low SoC reset (registered, high only in RUN)
//   o_fault     - high in FAULT (registered)
//   o_state     - current state encoding (see soc_rst_seq_pkg)
// Build option:
//   SOC_RST_SEQ_RETRY_EN - when defined, failed lock attempts are retried up
//   to RETRY_MAX times; when undefined any failed attempt goes to FAULT.
// -----------------------------------------------------------------------------
module soc_rst_seq
  import soc_rst_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 50000,
  parameter int unsigned HOLD_CYCLES    = 1024,
  parameter int unsigned RETRY_MAX      = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_pll_lock,
  output logic       o_pll_rst,
  output logic       o_soc_rst_n,
  output logic       o_fault,
  output logic [2:0] o_state
);

  localparam int unsigned RST_W  = cnt_width(PLL_RST_CYCLES);
  localparam int unsigned TMR_W  = cnt_width(LOCK_TIMEOUT);
  localparam int unsigned HOLD_W = cnt_width(HOLD_CYCLES);

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYCLES - 32'd1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LOCK_TIMEOUT - 32'd1);
  // The WAIT_LOCK cycle that sees lock already counts as one lock cycle,
  // so HOLD needs HOLD_CYCLES-1 more (at least one HOLD cycle is spent).
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'((HOLD_CYCLES >= 32'd2) ? (HOLD_CYCLES - 32'd2) : 32'd0);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                w_lock_s;
  logic [RST_W-1:0]    r_rst_cnt;
  logic [TMR_W-1:0]    r_lock_tmr;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                r_pll_rst;
  logic                r_soc_rst_n;
  logic                r_fault;

`ifdef SOC_RST_SEQ_RETRY_EN
  localparam int unsigned RETRY_W = cnt_width(RETRY_MAX);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_MAX);
  logic [RETRY_W-1:0]  r_retry;
  logic                w_retry_inc;
  logic                w_retry_clr;
`else
  // RETRY_MAX has no effect in this build.
  logic                w_unused_retry_max;
  assign w_unused_retry_max = (RETRY_MAX > 32'd15);
`endif

  sync_2ff u_lock_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_pll_lock),
    .o_q     (w_lock_s)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_PLL_RST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decision; lock wins over a coincident timeout.
  always_comb begin
    w_state_nxt = r_state;
`ifdef SOC_RST_SEQ_RETRY_EN
    w_retry_inc = 1'b0;
    w_retry_clr = 1'b0;
`endif
    case (r_state)
      ST_PLL_RST: begin
        if (r_rst_cnt == RST_LAST) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else begin
          w_state_nxt = ST_PLL_RST;
        end
      end
      ST_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = ST_HOLD;
        end else if (r_lock_tmr == TMR_LAST) begin
`ifdef SOC_RST_SEQ_RETRY_EN
          if (r_retry < RETRY_LIM) begin
            w_state_nxt = ST_PLL_RST;
            w_retry_inc = 1'b1;
          end else begin
            w_state_nxt = ST_FAULT;
          end
`else
          w_state_nxt = ST_FAULT;
`endif
        end else begin
          w_state_nxt = ST_WAIT_LOCK;
        end
      end
      ST_HOLD: begin
        if (!w_lock_s) begin
          w_state_nxt = ST_PLL_RST;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_RUN: begin
        if (!w_lock_s) begin
          w_state_nxt = ST_PLL_RST;
`ifdef SOC_RST_SEQ_RETRY_EN
          w_retry_clr = 1'b1;
`endif
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FAULT: begin
        w_state_nxt = ST_FAULT;
      end
      default: begin
        w_state_nxt = ST_PLL_RST;
      end
    endcase
  end

  // Per-phase counters: advance while the phase continues, clear otherwise,
  // so each starts at zero on entry and saturates instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rst_cnt  <= {RST_W{1'b0}};
      r_lock_tmr <= {TMR_W{1'b0}};
      r_hold_cnt <= {HOLD_W{1'b0}};
    end else begin
      if ((r_state == ST_PLL_RST) && (w_state_nxt == ST_PLL_RST)) begin
        if (r_rst_cnt != RST_LAST) begin
          r_rst_cnt <= r_rst_cnt + RST_W'(1);
        end
      end else begin
        r_rst_cnt <= {RST_W{1'b0}};
      end
      if ((r_state == ST_WAIT_LOCK) && (w_state_nxt == ST_WAIT_LOCK)) begin
        if (r_lock_tmr != TMR_LAST) begin
          r_lock_tmr <= r_lock_tmr + TMR_W'(1);
        end
      end else begin
        r_lock_tmr <= {TMR_W{1'b0}};
      end
      if ((r_state == ST_HOLD) && (w_state_nxt == ST_HOLD)) begin
        if (r_hold_cnt != HOLD_LAST) begin
          r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
      end else begin
        r_hold_cnt <= {HOLD_W{1'b0}};
      end
    end
  end

`ifdef SOC_RST_SEQ_RETRY_EN
  // Failed-attempt count; a lock loss from RUN starts a fresh budget.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_retry <= {RETRY_W{1'b0}};
    end else if (w_retry_clr) begin
      r_retry <= {RETRY_W{1'b0}};
    end else if (w_retry_inc && (r_retry != RETRY_LIM)) begin
      r_retry <= r_retry + RETRY_W'(1);
    end
  end
`endif

  // Outputs are registered from the next state so they change on the same
  // edge as the state register and cannot glitch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pll_rst   <= 1'b1;
      r_soc_rst_n <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_pll_rst   <= (w_state_nxt == ST_PLL_RST) || (w_state_nxt == ST_FAULT);
      r_soc_rst_n <= (w_state_nxt == ST_RUN);
      r_fault     <= (w_state_nxt == ST_FAULT);
    end
  end

  assign o_pll_rst   = r_pll_rst;
  assign o_soc_rst_n = r_soc_rst_n;
  assign o_fault     = r_fault;
  assign o_state     = r_state;

endmodule
